minicpu_sequencer: RTL

MINICPU_SEQUENCER -- requirements
Module: minicpu_sequencer

---
 rtl/minicpu_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/minicpu_sequencer.sv
// Program buffer and issue sequencer that feeds 12-bit instruction words to a MiniCPU,
// holding each word for HOLD cycles and tracking result/overflow at the end of each window.
module minicpu_sequencer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned HOLD     = 2,
  parameter logic [11:0] NOP_WORD = 12'hF00,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          wr_en_i,
  input  logic [11:0]   wr_data_i,
  input  logic          clear_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          halt_on_ovf_i,
  input  logic          overflow_i,
  input  logic [7:0]    result_i,
  output logic [11:0]   cpu_in_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          fault_o,
  output logic          full_o,
  output logic [AW-1:0] pc_o,
  output logic [AW:0]   count_o,
  output logic [7:0]    last_result_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, pc_next;
  logic [3:0]    hold_q, hold_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    last_result_q, last_result_d;
  logic [11:0]   cpu_in_q, cpu_in_d;
  logic [1:0]    rst_sync_q;
  logic          mem_we;
  logic          window_end;
  logic          last_word;
  logic          full;

  logic [11:0]   mem [DEPTH];

  // Reset asserts immediately but releases only after two clean edges with rst_n_i high.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign window_end = (hold_q == 4'(HOLD - 1));
  assign last_word  = ({1'b0, pc_q} == (count_q - (AW+1)'(1)));
  assign full       = (count_q == (AW+1)'(DEPTH));
  assign pc_next    = pc_q + AW'(1);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_d        = hold_q;
    count_d       = count_q;
    last_result_d = last_result_q;
    cpu_in_d      = NOP_WORD;
    mem_we        = 1'b0;

    if (clear_i) begin
      state_d = S_IDLE;
      count_d = '0;
      pc_d    = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (abort_i) begin
            state_d = S_IDLE;
            hold_d  = '0;
          end else if (!window_end) begin
            hold_d   = 4'(hold_q + 4'd1);
            cpu_in_d = mem[pc_q];
          end else begin
            last_result_d = result_i;
            hold_d        = '0;
            if (overflow_i && halt_on_ovf_i) begin
              state_d = S_FAULT;
            end else if (last_word) begin
              state_d = S_DONE;
            end else begin
              pc_d     = pc_next;
              cpu_in_d = mem[pc_next];
            end
          end
        end
        default: begin
          if (wr_en_i && !full) begin
            mem_we  = 1'b1;
            count_d = count_q + (AW+1)'(1);
          end
          if (start_i && (count_q != '0)) begin
            state_d  = S_RUN;
            pc_d     = '0;
            hold_d   = '0;
            cpu_in_d = mem[0];
          end
        end
      endcase
    end

    // Keep everything parked at reset values until the synchronized release arrives.
    if (!rst_sync_q[1]) begin
      state_d       = S_IDLE;
      pc_d          = '0;
      hold_d        = '0;
      count_d       = '0;
      last_result_d = '0;
      cpu_in_d      = NOP_WORD;
      mem_we        = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      hold_q        <= '0;
      count_q       <= '0;
      last_result_q <= '0;
      cpu_in_q      <= NOP_WORD;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_q        <= hold_d;
      count_q       <= count_d;
      last_result_q <= last_result_d;
      cpu_in_q      <= cpu_in_d;
    end
  end

  // Storage has no reset so it can map onto plain RAM; contents survive CLEAR.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[count_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign cpu_in_o      = cpu_in_q;
  assign busy_o        = (state_q == S_RUN);
  assign done_o        = (state_q == S_DONE);
  assign fault_o       = (state_q == S_FAULT);
  assign full_o        = full;
  assign pc_o          = pc_q;
  assign count_o       = count_q;
  assign last_result_o = last_result_q;

endmodule
